bus_rr: RTL
===========

# bus_rr

Parametrised multi-master, multi-slave system bus, successor to the single-master bus. Arbitrates NUM_M masters with a registered round-robin arbiter and decodes the owner's address into one-hot slave selects. Forwards the owner's write data and address to the slaves. Returns the selected slave's read data to the masters one cycle later. Sits between the CPU/DMA masters and the memory/peripheral slaves.

## Interface
- NUM_M, 2: number of masters, 2..8.
- NUM_S, 2: number of slaves, 1..2**SELW.
- SELW, 1: address MSBs used for slave decode.
- AW, 16: address width.
- DW, 64: data width.
- MAX_HOLD, 8: tenure limit in cycles; used only with BUS_RR_TIMEOUT_EN.
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- m_req  in  NUM_M  per-master bus request.
- m_wr  in  NUM_M  per-master write (1) / read (0).
- m_addr  in  NUM_M*AW  per-master address; master i occupies bits [i*AW +: AW].
- m_dout  in  NUM_M*DW  per-master write data; master i occupies bits [i*DW +: DW].
- m_grant  out  NUM_M  one-hot or zero grant.
- m_din  out  DW  read data, broadcast to all masters.
- s_sel  out  NUM_S  one-hot or zero slave select.
- s_wr  out  1  write strobe to slaves.
- s_addr  out  AW  address to slaves.
- s_din  out  DW  write data to slaves.
- s_dout  in  NUM_S*DW  per-slave read data; slave k occupies bits [k*DW +: DW].

## Operation
- Arbiter states:
  - IDLE: m_grant == 0.
  - OWN(i): m_grant == 1<<i.
- Each clock edge:
  - In OWN(i) with m_req[i]=1 and no preemption, stay in OWN(i).
  - Otherwise grant the first requester found scanning i+1, i+2, … (mod NUM_M), i included last.
  - If no master is requesting, go to IDLE.
- From IDLE, scan starts at last_owner+1.
- last_owner updates whenever a grant is issued.
- Active cycle: m_grant[i]=1 and m_req[i]=1. During an active cycle:
  - s_addr = m_addr[i], s_din = m_dout[i], s_wr = m_wr[i].
  - idx = s_addr[AW-1 -: SELW]. s_sel[idx] = 1 if idx < NUM_S; otherwise s_sel = 0 (unmapped).
- Non-active cycles: s_sel, s_wr, s_addr and s_din are all 0.
- Read return:
  - The registered rd_idx captures idx and a valid bit for active, mapped, read cycles.
  - Next cycle, m_din = s_dout[rd_idx] if valid, else 0.
  - Writes and unmapped accesses return m_din = 0.
- Simultaneous requests are resolved purely by rotation order; there is no fixed priority.
- Reset, including mid-transfer, takes effect on the next edge:
  - m_grant = 0, last_owner = NUM_M-1 (master 0 is checked first).
  - rd valid = 0, hold counter = 0.
  - All outputs read 0 in the cycle after reset is sampled.

## Timing
- Grant latency: m_req rising in cycle t gives m_grant in t+1 if the bus is idle.
- Release: owner drops m_req in cycle t.
  - Cycle t is inactive; its grant is still high but s_sel = 0.
  - Next owner's grant appears in t+1, so handover costs one dead cycle.
- Read data latency: exactly one cycle after the active read cycle.
- Back-to-back reads by the same owner stream one result per cycle.
- m_grant, last_owner and rd_idx are registered.
- s_* outputs are combinational from the registered grant and the master inputs.
- m_din is combinational from rd_idx and s_dout.

## Configuration
- BUS_RR_TIMEOUT_EN defined:
  - A hold counter increments on every cycle of the same OWN(i).
  - When the counter reaches MAX_HOLD-1 and any other master is requesting, the next edge forces re-arbitration, skipping i.
  - The counter clears on every owner change and in IDLE.
  - A lone requester is never preempted.
- BUS_RR_TIMEOUT_EN undefined:
  - No counter exists; the owner holds the bus until it drops m_req.
  - MAX_HOLD is ignored.

## Test plan
- Reset: assert reset for 2 cycles while m_req = all ones -> m_grant = 0, s_sel = 0, m_din = 0. Release -> master 0 granted the next cycle.
- Round-robin: NUM_M=3, all masters request continuously, each drops m_req after 2 active cycles -> grant order 0, 1, 2, 0, with one dead cycle per handover.
- Decode and read: master 1 reads address 16'h8004 with s_dout of slave 1 = 64'hDEAD_BEEF_0000_0001 -> s_sel = 2'b10, s_wr = 0. Next cycle m_din = 64'hDEAD_BEEF_0000_0001.
- Write path: master 0 writes address 16'h0010 with data 64'h1234 -> s_sel = 2'b01, s_wr = 1, s_din = 64'h1234. Next cycle m_din = 0.
- Unmapped access: NUM_S=1, SELW=1, read of address 16'h8000 -> s_sel = 0. Next cycle m_din = 0.
- Timeout (BUS_RR_TIMEOUT_EN, MAX_HOLD=4): master 0 holds m_req with master 1 requesting -> master 0 granted for exactly 4 cycles, then master 1. Same stimulus without the macro -> master 0 keeps the grant indefinitely.

Source files
------------

// File: rtl/bus_rr.sv
// -----------------------------------------------------------------------------
// bus_rr -- multi-master / multi-slave system bus with round-robin arbitration
//
// Purpose:
//   Arbitrates NUM_M masters using a registered round-robin arbiter. It forwards
//   the current owner's address, write data and write strobe to the slaves. It
//   decodes the top SELW address bits into a one-hot slave select. Read data
//   from the selected slave is returned one cycle after the read was issued.
//
// Optional feature (compile-time macro BUS_RR_TIMEOUT_EN):
//   When defined, an owner that has held the bus for MAX_HOLD cycles is
//   preempted if any other master is requesting. When undefined, an owner keeps
//   the bus until it drops its request, and MAX_HOLD has no effect.
//
// Ports:
//   clk      in   clock; all state changes on the rising edge
//   reset    in   synchronous active-high reset
//   m_req    in   [NUM_M]     per-master request
//   m_wr     in   [NUM_M]     per-master write(1)/read(0)
//   m_addr   in   [NUM_M*AW]  per-master address, master i at [i*AW +: AW]
//   m_dout   in   [NUM_M*DW]  per-master write data, master i at [i*DW +: DW]
//   m_grant  out  [NUM_M]     one-hot or zero grant (registered)
//   m_din    out  [DW]        read data broadcast to all masters
//   s_sel    out  [NUM_S]     one-hot or zero slave select
//   s_wr     out              write strobe to the slaves
//   s_addr   out  [AW]        address to the slaves
//   s_din    out  [DW]        write data to the slaves
//   s_dout   in   [NUM_S*DW]  per-slave read data, slave k at [k*DW +: DW]
// -----------------------------------------------------------------------------
module bus_rr #(
  parameter int NUM_M    = 2,
  parameter int NUM_S    = 2,
  parameter int SELW     = 1,
  parameter int AW       = 16,
  parameter int DW       = 64,
  parameter int MAX_HOLD = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_M-1:0]      m_req,
  input  logic [NUM_M-1:0]      m_wr,
  input  logic [NUM_M*AW-1:0]   m_addr,
  input  logic [NUM_M*DW-1:0]   m_dout,
  output logic [NUM_M-1:0]      m_grant,
  output logic [DW-1:0]         m_din,
  output logic [NUM_S-1:0]      s_sel,
  output logic                  s_wr,
  output logic [AW-1:0]         s_addr,
  output logic [DW-1:0]         s_din,
  input  logic [NUM_S*DW-1:0]   s_dout
);

  localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OWN  = 1'b1;

  // Reject illegal configurations at elaboration.
  if (NUM_M < 2 || NUM_M > 8 || NUM_S < 1 || NUM_S > (1 << SELW) ||
      SELW < 1 || SELW > AW || MAX_HOLD < 1) begin : g_param_err
    $error("bus_rr: illegal parameter combination");
  end

  // ---------------------------------------------------------------------------
  // Arbiter state
  // ---------------------------------------------------------------------------
  logic [0:0]       state_q, state_d;
  logic [IW-1:0]    cur_q,   cur_d;    // current owner (valid in ST_OWN)
  logic [IW-1:0]    last_q,  last_d;   // most recently granted master
  logic [NUM_M-1:0] grant_q, grant_d;

  logic             preempt;
  logic             keep;
  logic             found;
  logic [IW-1:0]    base;
  logic [IW-1:0]    pick_idx;
  int               cand;

`ifdef BUS_RR_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hold_q, hold_d;
`endif

  always_comb begin
    preempt = 1'b0;
`ifdef BUS_RR_TIMEOUT_EN
    // Tenure expired and someone else is waiting; a lone requester keeps going.
    preempt = (state_q == ST_OWN) && (hold_q == HW'(MAX_HOLD - 1)) &&
              ((m_req & ~grant_q) != '0);
`endif
    keep = (state_q == ST_OWN) && m_req[cur_q] && !preempt;

    // Rotation starts just after the owner, or after the last owner when idle.
    base     = (state_q == ST_OWN) ? cur_q : last_q;
    found    = 1'b0;
    pick_idx = '0;
    cand     = 0;
    for (int k = 1; k <= NUM_M; k++) begin
      cand = int'(base) + k;
      if (cand >= NUM_M) cand = cand - NUM_M;
      // On preemption the old owner is skipped even if it still requests.
      if (!found && m_req[cand] &&
          !(preempt && (cand == int'(cur_q)))) begin
        found    = 1'b1;
        pick_idx = IW'(cand);
      end
    end

    if (keep) begin
      state_d = ST_OWN;
      cur_d   = cur_q;
    end else if (found) begin
      state_d = ST_OWN;
      cur_d   = pick_idx;
    end else begin
      state_d = ST_IDLE;
      cur_d   = cur_q;
    end

    last_d = (state_d == ST_OWN) ? cur_d : last_q;

`ifdef BUS_RR_TIMEOUT_EN
    // Count cycles of an unbroken tenure, saturating at the limit.
    if (keep) begin
      hold_d = (hold_q == HW'(MAX_HOLD - 1)) ? hold_q : hold_q + HW'(1);
    end else begin
      hold_d = '0;
    end
`endif
  end

  for (genvar gi = 0; gi < NUM_M; gi++) begin : g_grant
    assign grant_d[gi] = (state_d == ST_OWN) && (int'(cur_d) == gi);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      last_q  <= IW'(NUM_M - 1);   // master 0 is scanned first after reset
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      grant_q <= grant_d;
    end
  end

`ifdef BUS_RR_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`endif

  assign m_grant = grant_q;

  // ---------------------------------------------------------------------------
  // Owner datapath mux and slave decode
  // ---------------------------------------------------------------------------
  logic [AW-1:0]   own_addr;
  logic [DW-1:0]   own_data;
  logic            own_wr;
  logic            active;
  logic [SELW-1:0] idx;
  logic            mapped;

  always_comb begin
    own_addr = '0;
    own_data = '0;
    own_wr   = 1'b0;
    for (int j = 0; j < NUM_M; j++) begin
      if (grant_q[j]) begin
        own_addr = m_addr[j*AW +: AW];
        own_data = m_dout[j*DW +: DW];
        own_wr   = m_wr[j];
      end
    end
  end

  // A granted master that has dropped its request is a dead cycle.
  assign active = |(grant_q & m_req);

  assign s_addr = active ? own_addr : '0;
  assign s_din  = active ? own_data : '0;
  assign s_wr   = active & own_wr;

  assign idx    = s_addr[AW-1 -: SELW];
  assign mapped = int'(idx) < NUM_S;

  for (genvar gi = 0; gi < NUM_S; gi++) begin : g_sel
    assign s_sel[gi] = active && (int'(idx) == gi);
  end

  // ---------------------------------------------------------------------------
  // Read return path: remember which slave was read, mux its data next cycle
  // ---------------------------------------------------------------------------
  logic            rd_valid_q, rd_valid_d;
  logic [SELW-1:0] rd_idx_q,   rd_idx_d;

  assign rd_valid_d = active && !own_wr && mapped;
  assign rd_idx_d   = idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_idx_q   <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_idx_q   <= rd_idx_d;
    end
  end

  always_comb begin
    m_din = '0;
    for (int k = 0; k < NUM_S; k++) begin
      if (rd_valid_q && (int'(rd_idx_q) == k)) begin
        m_din = s_dout[k*DW +: DW];
      end
    end
  end

endmodule
